// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - RV32I instruction fetch stage with single-outstanding imem handshake
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Ins,
   output logic        Ins_valid,
   input  logic        Ins_ready,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   input  logic        redirect,
   input  logic [31:0] PCTarget,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        w_req;
   logic        w_capture;
   logic        w_consume;
   logic [31:0] w_target;

   logic [31:0] r_fetch_pc;
   logic [31:0] r_ins;
   logic        r_ins_valid;
   logic [31:0] r_pc;
   logic [31:0] r_pc_plus4;
   logic        r_fetch_err;

   // Redirect targets are forced to word alignment; a misaligned target only raises fetch_err.
   assign w_target  = {PCTarget[31:2], 2'b00};

   // Response is captured only in S_WAIT and only when no redirect cancels it in the same cycle.
   assign w_capture = (r_state == S_WAIT) && imem_rvalid && !redirect;
   assign w_consume = (r_state == S_FULL) && Ins_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and request decode; redirect takes priority over every other event.
   always_comb begin
      w_next_state = r_state;
      w_req        = 1'b0;
      case (r_state)
         S_REQ: begin
            w_req = 1'b1;
            if (redirect) begin
               // A grant in the redirect cycle still leaves a response to swallow.
               w_next_state = imem_gnt ? S_DROP : S_REQ;
            end else if (imem_gnt) begin
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               w_next_state = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               w_next_state = S_FULL;
            end
         end
         S_FULL: begin
            if (redirect || Ins_ready) begin
               w_next_state = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               w_next_state = S_REQ;
            end
         end
         default: begin
            w_next_state = S_REQ;
         end
      endcase
   end

   // Fetch PC, instruction register and sticky misalignment flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_pc  <= {RESET_PC[31:2], 2'b00};
         r_ins       <= NOP_INS;
         r_ins_valid <= 1'b0;
         r_pc        <= RESET_PC;
         r_pc_plus4  <= RESET_PC + 32'd4;
         r_fetch_err <= 1'b0;
      end else if (redirect) begin
         r_fetch_pc  <= w_target;
         r_ins       <= NOP_INS;
         r_ins_valid <= 1'b0;
         if (PCTarget[1:0] != 2'b00) begin
            r_fetch_err <= 1'b1;
         end
      end else if (w_capture) begin
         r_ins       <= imem_rdata;
         r_ins_valid <= 1'b1;
         r_pc        <= r_fetch_pc;
         r_pc_plus4  <= r_fetch_pc + 32'd4;
         r_fetch_pc  <= r_fetch_pc + 32'd4;
      end else if (w_consume) begin
         r_ins       <= NOP_INS;
         r_ins_valid <= 1'b0;
      end
   end

   // Request is suppressed while reset is held so memory never sees a request during reset.
   assign imem_req  = w_req && rst_n;
   assign imem_addr = r_fetch_pc;
   assign Ins       = r_ins;
   assign Ins_valid = r_ins_valid;
   assign PC        = r_pc;
   assign PCPlus4   = r_pc_plus4;
   assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with transaction-level reference model
module tb_ifetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] Ins;
   logic        Ins_valid;
   logic        Ins_ready = 1'b0;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        redirect = 1'b0;
   logic [31:0] PCTarget = 32'h0;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   ifetch_unit #(.RESET_PC(32'h0), .NOP_INS(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .Ins(Ins), .Ins_valid(Ins_valid), .Ins_ready(Ins_ready),
      .PC(PC), .PCPlus4(PCPlus4),
      .redirect(redirect), .PCTarget(PCTarget), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_data(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: next fetch address, one outstanding request (maybe cancelled), one held instruction.
   logic [31:0] m_pc, m_ins, m_pcv;
   logic        m_out, m_cancel, m_valid, m_err;

   always @(posedge clk) begin
      logic m_req, granted;
      m_req   = !m_out && !m_valid;
      granted = m_req && imem_gnt;
      if (!rst_n) begin
         m_pc = 32'h0; m_out = 0; m_cancel = 0; m_valid = 0;
         m_ins = NOP; m_pcv = 32'h0; m_err = 0;
      end else if (redirect) begin
         if (PCTarget[1:0] != 2'b00) m_err = 1;
         m_valid = 0;
         m_ins   = NOP;
         m_pc    = PCTarget & 32'hFFFF_FFFC;
         if (granted) begin
            m_out = 1; m_cancel = 1;
         end else if (m_out && imem_rvalid) begin
            m_out = 0; m_cancel = 0;
         end else if (m_out) begin
            m_cancel = 1;
         end
      end else begin
         if (m_valid && Ins_ready) begin
            m_valid = 0; m_ins = NOP;
         end
         if (granted) begin
            m_out = 1; m_cancel = 0;
         end else if (m_out && imem_rvalid) begin
            if (!m_cancel) begin
               m_valid = 1; m_ins = imem_rdata; m_pcv = m_pc; m_pc = m_pc + 32'd4;
            end
            m_out = 0; m_cancel = 0;
         end
      end
      #1;
      chk("imem_req", {31'b0, imem_req}, {31'b0, rst_n && !m_out && !m_valid});
      if (rst_n && !m_out && !m_valid) chk("imem_addr", imem_addr, m_pc);
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      chk("Ins_valid", {31'b0, Ins_valid}, {31'b0, m_valid});
      chk("Ins", Ins, m_ins);
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      if (m_valid) begin
         chk("PC", PC, m_pcv);
         chk("PCPlus4", PCPlus4, m_pcv + 32'd4);
      end
   end

   task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr, input logic [31:0] tgt);
      imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
      Ins_ready = rdy; redirect = rdr; PCTarget = tgt;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
      chk({tag, "_valid"}, {31'b0, Ins_valid}, 32'h0);
      chk({tag, "_ins"}, Ins, NOP);
      chk({tag, "_pc"}, PC, 32'h0);
      chk({tag, "_pc4"}, PCPlus4, 32'h4);
      chk({tag, "_err"}, {31'b0, fetch_err}, 32'h0);
   endtask

   // Directed scenarios with literal expectations, then randomized traffic from a memory model.
   initial begin
      logic        busy, p_rst, p_rv, p_req, p_gnt;
      logic [31:0] maddr, p_addr;
      int          cnt;

      repeat (2) @(negedge clk);
      #1; chk_reset_vals("rst0");

      @(negedge clk); rst_n = 1; set_in(1, 0, 0, 0, 0, 0);
      #1; chk("t1_req", {31'b0, imem_req}, 32'h1); chk("t1_addr", imem_addr, 32'h0);
      @(negedge clk); set_in(0, 1, 32'h0050_0093, 0, 0, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
      #1; chk("t1_valid", {31'b0, Ins_valid}, 32'h1); chk("t1_ins", Ins, 32'h0050_0093);
      chk("t1_pc", PC, 32'h0); chk("t1_pc4", PCPlus4, 32'h4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("t2_valid", {31'b0, Ins_valid}, 32'h1); chk("t2_ins", Ins, 32'h0050_0093);
         chk("t2_pc", PC, 32'h0); chk("t2_req", {31'b0, imem_req}, 32'h0);
      end
      @(negedge clk); set_in(0, 0, 0, 1, 0, 0);
      @(negedge clk); set_in(1, 0, 0, 0, 0, 0);
      #1; chk("t2_next_req", {31'b0, imem_req}, 32'h1); chk("t2_next_addr", imem_addr, 32'h4);

      @(negedge clk); set_in(0, 0, 0, 0, 1, 32'h100);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk); set_in(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      #1; chk("t3_drop_valid", {31'b0, Ins_valid}, 32'h0);
      @(negedge clk); set_in(1, 0, 0, 0, 0, 0);
      #1; chk("t3_valid", {31'b0, Ins_valid}, 32'h0);
      chk("t3_req", {31'b0, imem_req}, 32'h1); chk("t3_addr", imem_addr, 32'h100);

      @(negedge clk); set_in(0, 1, 32'h1111_2222, 0, 1, 32'h40);
      @(negedge clk); set_in(0, 0, 0, 0, 1, 32'h102);
      #1; chk("t4_valid", {31'b0, Ins_valid}, 32'h0);
      chk("t4_req", {31'b0, imem_req}, 32'h1); chk("t4_addr", imem_addr, 32'h40);

      @(negedge clk); set_in(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      #1; chk("t5_err", {31'b0, fetch_err}, 32'h1); chk("t5_addr", imem_addr, 32'h100);

      @(negedge clk); set_in(1, 0, 0, 0, 0, 0);
      #1; chk("t6_addr", imem_addr, 32'hFFFF_FFFC); chk("t6_err", {31'b0, fetch_err}, 32'h1);
      @(negedge clk); set_in(0, 1, 32'h1234_5678, 0, 0, 0);
      @(negedge clk); set_in(0, 0, 0, 1, 0, 0);
      #1; chk("t6_valid", {31'b0, Ins_valid}, 32'h1); chk("t6_pc", PC, 32'hFFFF_FFFC);
      chk("t6_pc4", PCPlus4, 32'h0); chk("t6_ins", Ins, 32'h1234_5678);
      @(negedge clk); set_in(1, 0, 0, 0, 0, 0);
      #1; chk("t6_wrap_req", {31'b0, imem_req}, 32'h1); chk("t6_wrap_addr", imem_addr, 32'h0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0); rst_n = 0;
      #1; chk("t6_rst_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk);
      #1; chk_reset_vals("rst1");

      busy = 0; cnt = 0; maddr = 0;
      p_rst = 0; p_rv = 0; p_req = 0; p_gnt = 0; p_addr = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!p_rst) begin
            busy = 0;
         end else begin
            if (p_rv) busy = 0;
            if (p_req && p_gnt) begin
               busy = 1; maddr = p_addr; cnt = $urandom_range(0, 2);
            end else if (busy && cnt > 0) begin
               cnt--;
            end
         end
         rst_n = ($urandom_range(0, 299) != 0);
         #1;
         imem_rvalid = rst_n && busy && (cnt == 0);
         imem_rdata  = imem_rvalid ? mk_data(maddr) : $urandom;
         imem_gnt    = imem_req && !busy && ($urandom_range(0, 1) == 1);
         Ins_ready   = ($urandom_range(0, 2) != 0);
         redirect    = ($urandom_range(0, 9) == 0);
         PCTarget    = $urandom;
         if ($urandom_range(0, 7) != 0) PCTarget[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0) PCTarget = 32'hFFFF_FFF0 | (PCTarget & 32'hF);
         p_rst = rst_n; p_rv = imem_rvalid; p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage of the single-cycle RV32I core. It sits directly upstream of decode and the immediate extender. It owns the program counter and issues one word request at a time to instruction memory over a grant/valid handshake. Each returned word is registered and presented as Ins with a valid/ready handshake, together with its PC and PC+4. Branch and jump targets arrive as a redirect and cancel any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, address fetched first after reset.
NOP_INS, 32'h0000_0013, value driven on Ins whenever no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rst_n  input  1  synchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  word-aligned fetch address; bits [1:0] are always 0.
imem_gnt  input  1  memory accepts the request this cycle (sampled only while imem_req=1).
imem_rvalid  input  1  read data valid, at least one cycle after imem_gnt.
imem_rdata  input  32  instruction word.
Ins  output  32  registered instruction to decode and the immediate extender.
Ins_valid  output  1  Ins, PC and PCPlus4 hold a live instruction.
Ins_ready  input  1  decode consumes the instruction (transfer when Ins_valid && Ins_ready).
PC  output  32  address of the instruction on Ins.
PCPlus4  output  32  PC + 4, wrapping modulo 2^32.
redirect  input  1  taken branch or jump this cycle.
PCTarget  input  32  new fetch address, sampled when redirect=1.
fetch_err  output  1  sticky flag: a misaligned redirect target was seen.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets:
  - state=S_REQ, fetch_pc=RESET_PC.
  - imem_req=0 (held low while rst_n=0), Ins=NOP_INS, Ins_valid=0.
  - PC=RESET_PC, PCPlus4=RESET_PC+4, fetch_err=0.
- Reset mid-fetch abandons the outstanding request. Memory is also reset by rst_n, so no stale rvalid is expected.
- State S_REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_gnt, go to S_WAIT.
- State S_WAIT:
  - imem_req=0.
  - On imem_rvalid, register Ins=imem_rdata, PC=fetch_pc, PCPlus4=fetch_pc+4, Ins_valid=1; set fetch_pc += 4; go to S_FULL.
- State S_FULL:
  - imem_req=0. Ins, PC and PCPlus4 are held stable while Ins_valid && !Ins_ready.
  - On Ins_ready, set Ins_valid=0 and Ins=NOP_INS at the next edge, and go to S_REQ.
- State S_DROP:
  - Waits for the response to a cancelled request. imem_req=0.
  - On imem_rvalid, discard imem_rdata and go to S_REQ.
- Only one request is ever outstanding; imem_req is never high in S_WAIT or S_DROP.
- Minimum cadence is 3 cycles per instruction (REQ, WAIT, FULL) with gnt and rvalid returned in consecutive cycles.
- Redirect has priority over every other event in every state:
  - Always: fetch_pc <= {PCTarget[31:2],2'b00}, Ins_valid <= 0, Ins <= NOP_INS.
  - In S_REQ without imem_gnt: stay in S_REQ; imem_addr takes the new address from the next cycle.
  - In S_REQ with imem_gnt in the same cycle: the old request is accepted, so go to S_DROP.
  - In S_WAIT without imem_rvalid: go to S_DROP.
  - In S_WAIT with imem_rvalid in the same cycle: discard the data and go to S_REQ.
  - In S_FULL: drop the held instruction (regardless of Ins_ready) and go to S_REQ.
  - In S_DROP: update fetch_pc and stay until rvalid.
- Misaligned target: if redirect=1 and PCTarget[1:0]!=0, fetch_err=1 from the next cycle until reset. Fetch continues from the aligned address.
- imem_addr changes while imem_req=1 only due to redirect.
- All PC arithmetic is 32-bit unsigned and wraps: PC 32'hFFFF_FFFC gives PCPlus4 32'h0000_0000.

Test Plan:
1. Reset then release; memory grants immediately and returns 32'h00500093 one cycle later.
   -> Cycle 1: imem_req=1, imem_addr=0.
   -> Ins_valid=1, Ins=32'h00500093, PC=0, PCPlus4=4.
   -> Next request is to address 4 after Ins_ready=1.
2. Backpressure: Ins_ready=0 for 5 cycles while in S_FULL.
   -> Ins, PC and Ins_valid stay constant; imem_req=0 throughout.
   -> One cycle after Ins_ready=1, the fetch to PC+4 is issued.
3. Redirect in S_WAIT, PCTarget=32'h0000_0100; rvalid arrives 2 cycles later with 32'hDEADBEEF.
   -> Data is discarded; Ins_valid is never set for it.
   -> Next imem_addr=32'h100.
4. Redirect in the same cycle as imem_rvalid (PCTarget=32'h40).
   -> Ins_valid stays 0; the next cycle has imem_req=1, imem_addr=32'h40.
5. Redirect with PCTarget=32'h0000_0102.
   -> fetch_err=1 and stays 1; imem_addr=32'h100.
6. PC wrap: redirect to 32'hFFFF_FFFC, then a fetch.
   -> PC=32'hFFFF_FFFC, PCPlus4=0, next request to address 0.
   -> Assert rst_n=0 in S_WAIT: next cycle all outputs are at their reset values and imem_req=0.
